prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
Writer side of the instruction memory. The CPU only reads instruction memory; this block fills it. It accepts a byte stream over a valid/ready handshake and assembles 2*WORD_SIZE-bit instructions (hi byte first, matching the decoder's inst_hi/inst_lo split). It writes them to consecutive addresses from 0 and holds the CPU in reset until a checksummed load completes.

Parameters:
WORD_SIZE, 8, stream byte width; half-instruction width.
ADDR_SIZE, 8, instruction memory address width; must be >= WORD_SIZE.

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous, active-low reset
byte_in  input  WORD_SIZE  stream data
byte_valid  input  1  byte_in valid; held until accepted
byte_ready  output  1  loader can accept byte_in this cycle
start  input  1  single-cycle pulse; restarts a load from DONE or ERR
mem_data  output  2*WORD_SIZE  write data to instruction memory data_in
mem_addr  output  ADDR_SIZE  write address to instruction memory
mem_en_write  output  1  instruction memory write enable
cpu_rst  output  1  active-high reset to cpu; 1 while loading or after error
done  output  1  load completed with good checksum
error  output  1  load completed with bad checksum
count  output  ADDR_SIZE  number of instructions written in last/current load

Behaviour:
- Interface fixed: one clock (clk); reset rst_n is asynchronous and active-low.
- Stream format: LEN byte N (instruction count, 0..2^WORD_SIZE-1), then N pairs {HI, LO}, then CHK byte = XOR of all HI/LO bytes (LEN excluded).
- Byte transfer occurs on a rising edge with byte_valid && byte_ready. byte_ready is 1 in LEN, HI, LO and CHK, and 0 otherwise. byte_ready does not depend combinationally on byte_valid.
- States: LEN, HI, LO, WRITE, CHK, DONE, ERR.
- rst_n low (async, any time including mid-load): state=LEN, byte_ready=1 after release, cpu_rst=1, done=0, error=0, mem_en_write=0, mem_addr=0, mem_data=0, count=0, checksum accumulator=0. Memory contents already written are untouched.
- LEN transitions:
  - On accept, latch remaining=N, addr=0, xor=0, count=0.
  - If N==0, go to CHK; else go to HI.
- HI transitions: on accept, latch hi, xor^=byte; go to LO.
- LO transitions: on accept, latch lo, xor^=byte; go to WRITE.
- WRITE state:
  - Exactly one cycle: mem_en_write=1, mem_addr=addr, mem_data={hi,lo}; all three are registered outputs, stable for the whole cycle.
  - Next cycle: addr+1, count+1, remaining-1; go to CHK if remaining becomes 0, else go to HI.
  - mem_en_write=0 in every other state.
- Throughput: minimum 3 cycles per instruction (HI, LO, WRITE). If byte_valid is held high through WRITE, no byte is lost; it is accepted in the following HI.
- CHK transitions: on accept, compare byte to xor.
  - Equal: go to DONE.
  - Not equal: go to ERR.
- DONE outputs (registered, from the cycle after entry):
  - done=1, error=0, cpu_rst=0.
  - byte_ready=0; count holds the final value.
- ERR outputs: error=1, done=0, cpu_rst=1, byte_ready=0.
- start in DONE or ERR: go to LEN; done and error are cleared and cpu_rst=1 on the next cycle.
- start in any other state is ignored. start on the same edge as a CHK accept is also ignored.
- addr never wraps because N < 2^WORD_SIZE <= 2^ADDR_SIZE.

Decomposition:
- Shared package loader_pkg holds the state enum (LEN, HI, LO, WRITE, CHK, DONE, ERR) and the stream format constants.
- WORD_SIZE/ADDR_SIZE defaults stay in shared config.
- One natural sub-module: prog_checksum (XOR accumulator with clear, enable, byte in; WORD_SIZE-bit out).
- Everything else lives in a single FSM.

Test Plan:
- Good load: reset, stream 02,12,34,AB,CD,40 -> writes mem[0]=0x1234 and mem[1]=0xABCD, each with a one-cycle mem_en_write; done=1, cpu_rst=0, count=2.
- Bad checksum: same stream with CHK=41 -> error=1, done=0, cpu_rst stays 1. Then start pulse and the good stream -> done=1.
- Empty program: stream 00,00 -> no mem_en_write pulse, done=1, count=0. Stream 00,05 -> error=1.
- Backpressure and gaps: random byte_valid gaps with valid held across WRITE -> byte_ready=0 during WRITE, no byte dropped or duplicated, memory contents match the good-load case.
- Reset mid-load: rst_n low one cycle after HI=12 is accepted -> mem_en_write=0 immediately, cpu_rst=1, state LEN. A following stream 01,56,78,2E writes mem[0]=0x5678, done=1.
- Stray start: start pulse during HI and LO -> no state change, load completes normally.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory loader: default sizes,
// stream framing constants and the loader FSM state encoding.
package loader_pkg;

  localparam int WORD_SIZE_DEF = 8;
  localparam int ADDR_SIZE_DEF = 8;
  // Each instruction arrives as this many stream bytes, high byte first.
  localparam int INST_BYTES    = 2;

  typedef enum logic [2:0] {
    ST_LEN,
    ST_HI,
    ST_LO,
    ST_WRITE,
    ST_CHK,
    ST_DONE,
    ST_ERR
  } state_e;

endpackage

// File: rtl/prog_checksum.sv
// Running XOR of the instruction bytes of one load; clear wins over enable.
module prog_checksum #(
  parameter int WORD_SIZE = loader_pkg::WORD_SIZE_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 en,
  input  logic [WORD_SIZE-1:0] byte_in,
  output logic [WORD_SIZE-1:0] sum
);

  logic [WORD_SIZE-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clr)     sum_d = '0;
    else if (en) sum_d = sum_q ^ byte_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sum_q <= '0;
    else        sum_q <= sum_d;
  end

  assign sum = sum_q;

endmodule

// File: rtl/prog_loader.sv
// Fills instruction memory from a checksummed byte stream and holds the CPU
// in reset until a load has completed with a matching checksum.
module prog_loader
  import loader_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEF,
  parameter int ADDR_SIZE = ADDR_SIZE_DEF
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [WORD_SIZE-1:0]            byte_in,
  input  logic                            byte_valid,
  output logic                            byte_ready,
  input  logic                            start,
  output logic [INST_BYTES*WORD_SIZE-1:0] mem_data,
  output logic [ADDR_SIZE-1:0]            mem_addr,
  output logic                            mem_en_write,
  output logic                            cpu_rst,
  output logic                            done,
  output logic                            error,
  output logic [ADDR_SIZE-1:0]            count
);

  state_e                          state_q, state_d;
  logic [ADDR_SIZE-1:0]            addr_q, addr_d;
  logic [ADDR_SIZE-1:0]            count_q, count_d;
  logic [WORD_SIZE-1:0]            rem_q, rem_d;
  logic [WORD_SIZE-1:0]            hi_q, hi_d;
  logic [INST_BYTES*WORD_SIZE-1:0] data_q, data_d;
  logic                            wen_q, wen_d;
  logic                            done_q, done_d;
  logic                            error_q, error_d;
  logic                            cpu_rst_q, cpu_rst_d;
  logic                            chk_clr, chk_en;
  logic [WORD_SIZE-1:0]            chk_sum;
  logic                            accept;

  prog_checksum #(.WORD_SIZE(WORD_SIZE)) u_checksum (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (chk_clr),
    .en      (chk_en),
    .byte_in (byte_in),
    .sum     (chk_sum)
  );

  // Ready is a pure state decode so it never loops back through byte_valid.
  assign byte_ready = (state_q == ST_LEN) || (state_q == ST_HI) ||
                      (state_q == ST_LO)  || (state_q == ST_CHK);
  assign accept     = byte_valid && byte_ready;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    rem_d   = rem_q;
    hi_d    = hi_q;
    data_d  = data_q;
    wen_d   = 1'b0;
    chk_clr = 1'b0;
    chk_en  = 1'b0;
    unique case (state_q)
      ST_LEN: if (accept) begin
        rem_d   = byte_in;
        addr_d  = '0;
        count_d = '0;
        chk_clr = 1'b1;
        state_d = (byte_in == '0) ? ST_CHK : ST_HI;
      end
      ST_HI: if (accept) begin
        hi_d    = byte_in;
        chk_en  = 1'b1;
        state_d = ST_LO;
      end
      // Write strobe, address and data are all launched here so they are
      // registered and stable for the entire WRITE cycle.
      ST_LO: if (accept) begin
        data_d  = {hi_q, byte_in};
        chk_en  = 1'b1;
        wen_d   = 1'b1;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        addr_d  = addr_q + ADDR_SIZE'(1);
        count_d = count_q + ADDR_SIZE'(1);
        rem_d   = rem_q - WORD_SIZE'(1);
        state_d = (rem_q == WORD_SIZE'(1)) ? ST_CHK : ST_HI;
      end
      ST_CHK: if (accept) begin
        state_d = (byte_in == chk_sum) ? ST_DONE : ST_ERR;
      end
      ST_DONE, ST_ERR: if (start) state_d = ST_LEN;
      default: state_d = ST_LEN;
    endcase
    done_d    = (state_d == ST_DONE);
    error_d   = (state_d == ST_ERR);
    cpu_rst_d = (state_d != ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_LEN;
      addr_q    <= '0;
      count_q   <= '0;
      rem_q     <= '0;
      hi_q      <= '0;
      data_q    <= '0;
      wen_q     <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      cpu_rst_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      count_q   <= count_d;
      rem_q     <= rem_d;
      hi_q      <= hi_d;
      data_q    <= data_d;
      wen_q     <= wen_d;
      done_q    <= done_d;
      error_q   <= error_d;
      cpu_rst_q <= cpu_rst_d;
    end
  end

  assign mem_data     = data_q;
  assign mem_addr     = addr_q;
  assign mem_en_write = wen_q;
  assign done         = done_q;
  assign error        = error_q;
  assign cpu_rst      = cpu_rst_q;
  assign count        = count_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: good/bad/empty loads, backpressure with
// gaps, mid-load reset and stray start pulses, checked against known images.
module tb_prog_loader;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic        start = 1'b0;
  logic [15:0] mem_data;
  logic [7:0]  mem_addr;
  logic        mem_en_write;
  logic        cpu_rst;
  logic        done;
  logic        error;
  logic [7:0]  count;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          wr_cnt = 0;
  logic [15:0] tb_mem [0:255];

  prog_loader #(.WORD_SIZE(8), .ADDR_SIZE(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .byte_in      (byte_in),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .start        (start),
    .mem_data     (mem_data),
    .mem_addr     (mem_addr),
    .mem_en_write (mem_en_write),
    .cpu_rst      (cpu_rst),
    .done         (done),
    .error        (error),
    .count        (count)
  );

  always #5 clk = ~clk;

  // Memory image as seen by the instruction memory's write port.
  always @(negedge clk) begin
    if (mem_en_write === 1'b1) begin
      tb_mem[mem_addr] = mem_data;
      wr_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) tb_mem[i] = 16'hDEAD;
    wr_cnt = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic was_ready;
    int   waited;
    byte_in    = b;
    byte_valid = 1'b1;
    waited     = 0;
    do begin
      was_ready = byte_ready;
      @(posedge clk);
      #1;
      waited++;
    end while (!was_ready && waited < 50);
    byte_valid = 1'b0;
    if (!was_ready) check("accept_timeout", {31'b0, was_ready}, 32'd1);
  endtask

  task automatic send_seq(input bq_t s, input int max_gap);
    foreach (s[i]) begin
      send_byte(s[i]);
      if (max_gap > 0) begin
        repeat ($urandom_range(0, max_gap)) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  initial begin
    clear_mem();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    // Reset state
    check("rst_ready",   {31'b0, byte_ready},   32'd1);
    check("rst_cpu_rst", {31'b0, cpu_rst},      32'd1);
    check("rst_done",    {31'b0, done},         32'd0);
    check("rst_error",   {31'b0, error},        32'd0);
    check("rst_wen",     {31'b0, mem_en_write}, 32'd0);
    check("rst_addr",    {24'b0, mem_addr},     32'd0);
    check("rst_data",    {16'b0, mem_data},     32'd0);
    check("rst_count",   {24'b0, count},        32'd0);

    // Good load, with the first WRITE cycle inspected
    send_byte(8'h02);
    send_byte(8'h12);
    send_byte(8'h34);
    check("wr0_wen",   {31'b0, mem_en_write}, 32'd1);
    check("wr0_ready", {31'b0, byte_ready},   32'd0);
    check("wr0_addr",  {24'b0, mem_addr},     32'd0);
    check("wr0_data",  {16'b0, mem_data},     32'h1234);
    check("wr0_cpu",   {31'b0, cpu_rst},      32'd1);
    send_byte(8'hAB);
    send_byte(8'hCD);
    check("wr1_addr",  {24'b0, mem_addr},     32'd1);
    check("wr1_data",  {16'b0, mem_data},     32'hABCD);
    send_byte(8'h40);
    @(posedge clk); #1;
    check("good_done",  {31'b0, done},       32'd1);
    check("good_error", {31'b0, error},      32'd0);
    check("good_cpu",   {31'b0, cpu_rst},    32'd0);
    check("good_count", {24'b0, count},      32'd2);
    check("good_ready", {31'b0, byte_ready}, 32'd0);
    check("good_m0",    {16'b0, tb_mem[0]},  32'h1234);
    check("good_m1",    {16'b0, tb_mem[1]},  32'hABCD);
    check("good_wrs",   wr_cnt,              32'd2);

    // Bad checksum, then recovery via start
    pulse_start();
    check("restart_done", {31'b0, done},    32'd0);
    check("restart_cpu",  {31'b0, cpu_rst}, 32'd1);
    send_seq('{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41}, 0);
    @(posedge clk); #1;
    check("bad_error", {31'b0, error},   32'd1);
    check("bad_done",  {31'b0, done},    32'd0);
    check("bad_cpu",   {31'b0, cpu_rst}, 32'd1);
    check("bad_ready", {31'b0, byte_ready}, 32'd0);
    pulse_start();
    check("rst_err_clr", {31'b0, error}, 32'd0);
    send_seq('{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40}, 0);
    check("recov_done", {31'b0, done},    32'd1);
    check("recov_cpu",  {31'b0, cpu_rst}, 32'd0);

    // Empty program: good and bad checksum
    pulse_start();
    clear_mem();
    send_seq('{8'h00, 8'h00}, 0);
    repeat (2) @(posedge clk); #1;
    check("empty_done",  {31'b0, done},  32'd1);
    check("empty_count", {24'b0, count}, 32'd0);
    check("empty_wrs",   wr_cnt,         32'd0);
    pulse_start();
    send_seq('{8'h00, 8'h05}, 0);
    check("empty_bad_err",  {31'b0, error}, 32'd1);
    check("empty_bad_done", {31'b0, done},  32'd0);

    // Backpressure with random gaps
    pulse_start();
    clear_mem();
    send_seq('{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40}, 3);
    check("gap_done",  {31'b0, done},      32'd1);
    check("gap_count", {24'b0, count},     32'd2);
    check("gap_m0",    {16'b0, tb_mem[0]}, 32'h1234);
    check("gap_m1",    {16'b0, tb_mem[1]}, 32'hABCD);
    check("gap_wrs",   wr_cnt,             32'd2);

    // Reset in the middle of a load
    pulse_start();
    send_seq('{8'h02, 8'h12}, 0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_wen",   {31'b0, mem_en_write}, 32'd0);
    check("mid_cpu",   {31'b0, cpu_rst},      32'd1);
    check("mid_ready", {31'b0, byte_ready},   32'd1);
    check("mid_count", {24'b0, count},        32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_mem();
    send_seq('{8'h01, 8'h56, 8'h78, 8'h2E}, 0);
    check("mid_done",  {31'b0, done},      32'd1);
    check("mid_m0",    {16'b0, tb_mem[0]}, 32'h5678);
    check("mid_cnt2",  {24'b0, count},     32'd1);
    check("mid_wrs",   wr_cnt,             32'd1);

    // Stray start pulses during HI, LO and with the CHK byte
    pulse_start();
    clear_mem();
    send_seq('{8'h02, 8'h12}, 0);
    pulse_start();
    check("stray_lo_ready", {31'b0, byte_ready},   32'd1);
    check("stray_lo_wen",   {31'b0, mem_en_write}, 32'd0);
    send_byte(8'h34);
    @(posedge clk); #1;
    pulse_start();
    check("stray_hi_ready", {31'b0, byte_ready}, 32'd1);
    check("stray_hi_cpu",   {31'b0, cpu_rst},    32'd1);
    send_seq('{8'hAB, 8'hCD}, 0);
    start = 1'b1;
    send_byte(8'h40);
    start = 1'b0;
    check("stray_done", {31'b0, done},      32'd1);
    @(posedge clk); #1;
    check("stray_hold", {31'b0, done},      32'd1);
    check("stray_m0",   {16'b0, tb_mem[0]}, 32'h1234);
    check("stray_m1",   {16'b0, tb_mem[1]}, 32'hABCD);
    check("stray_wrs",  wr_cnt,             32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
